ex_mem_wb_pipe: RTL and testbench
=================================

# ex_mem_wb_pipe

Back half of the 5-stage RV32I pipeline: the EX/MEM and MEM/WB pipeline registers plus the data-memory handshake between them. Captures EX-stage results, runs at most one data-memory access per instruction with a ready/valid stall, and produces the write-back record. Drives `ex_mem_rd`, `ex_mem_RW`, `mem_wb_rd`, `mem_wb_RW` and both forwarding data values into the forwarding unit and EX operand muxes.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `ex_valid`  in  1  EX holds a real instruction (0 = bubble)
- `ex_rd`  in  5  destination register
- `ex_reg_write`  in  1  instruction writes rd
- `ex_mem_read` / `ex_mem_write`  in  1 each  load / store
- `ex_mem_to_reg`  in  1  write-back selects load data
- `ex_alu_result`  in  XLEN  ALU result / memory address
- `ex_store_data`  in  XLEN  forwarded rs2 value for stores
- `ex_is_halt`  in  1  ECALL-halt marker
- `dmem_req`  out  1  access request
- `dmem_we`  out  1  1 = store
- `dmem_addr`, `dmem_wdata`  out  XLEN  address, store data
- `dmem_ready`  in  1  access completes this cycle
- `dmem_rdata`  in  XLEN  load data, valid when `dmem_ready`
- `mem_stall`  out  1  EX/MEM cannot advance; upstream holds
- `ex_mem_rd`  out  5;  `ex_mem_RW`  out  1;  `ex_mem_alu_result`  out  XLEN
- `mem_wb_rd`  out  5;  `mem_wb_RW`  out  1;  `mem_wb_data`  out  XLEN  final write-back value
- `halted`  out  1  sticky, halt instruction retired
- `stall_cycles`  out  32  count of cycles with `mem_stall`=1

## Operation
- EX/MEM register: fields valid, rd, reg_write, mem_read, mem_write, mem_to_reg, alu_result, store_data, is_halt. Loads from EX inputs each cycle unless `mem_stall`=1 (hold).
- `ex_mem_RW` = EX/MEM.valid & reg_write & (rd != 0). `mem_wb_RW` same rule on MEM/WB. Bubbles and x0 writes never request forwarding.
- Memory FSM, states IDLE, WAIT:
  - IDLE: if EX/MEM valid & (mem_read | mem_write): `dmem_req`=1. `dmem_ready`=1 → access done, no stall. Else `mem_stall`=1, go WAIT.
  - WAIT: `dmem_req`=1 with `dmem_addr`/`dmem_wdata`/`dmem_we` held stable, `mem_stall`=1 until `dmem_ready`; on ready go IDLE, no stall that cycle.
  - Non-memory instruction or bubble: `dmem_req`=0, no stall.
- `dmem_we` = mem_write; a single instruction never issues two requests.
- MEM/WB register: each edge loads from EX/MEM; `mem_wb_data` = mem_to_reg ? `dmem_rdata` : alu_result. If `mem_stall`=1, MEM/WB loads a bubble (valid=0).
- `halted` sets when MEM/WB captures valid is_halt; clears only on reset.
- `stall_cycles` increments while `mem_stall`=1; saturates at all-ones.

## Timing
- Reset: every valid bit 0, all rd/data/control fields 0, FSM IDLE, `dmem_req`=0, `mem_stall`=0, `halted`=0, `stall_cycles`=0; all outputs 0 the cycle after reset is sampled.
- Latency: EX → EX/MEM 1 cycle; EX/MEM → MEM/WB 1 cycle with zero-wait memory, 1+N with N wait cycles.
- `mem_stall` is combinational from FSM state, EX/MEM fields and `dmem_ready`; no registered delay.
- `dmem_ready` outside a request is ignored.
- Reset mid-WAIT: abandon access, `dmem_req` drops next cycle, in-flight instruction lost.
- Store followed by load to same address: store completes before load issues (in-order, one outstanding).

## Structure
- Shared package `pipe_pkg`: EX/MEM and MEM/WB record typedefs, `mem_state_t` {IDLE, WAIT}, `X0` constant.
- One natural sub-module: `dmem_handshake` (FSM, `dmem_*` drive, `mem_stall`). Pipeline registers stay in the top.

## Test plan
- ALU op rd=5, result 0x1234 → next cycle `ex_mem_RW`=1, `ex_mem_rd`=5; following cycle `mem_wb_data`=0x1234, `mem_wb_RW`=1.
- Write to rd=0 with reg_write=1 → `ex_mem_RW`=0 and `mem_wb_RW`=0 throughout.
- Load addr 0x40, `dmem_ready` low 3 cycles then high with rdata 0xDEADBEEF → `mem_stall`=1 for 3 cycles, addr stable, 3 bubbles in MEM/WB, then `mem_wb_data`=0xDEADBEEF; `stall_cycles`=3.
- Store 0x55 to 0x80, ready same cycle → `dmem_we`=1, `dmem_wdata`=0x55, no stall, `mem_wb_RW`=0.
- Reset asserted in WAIT → next cycle `dmem_req`=0, all valid/RW 0, FSM IDLE.
- Halt instruction → `halted`=1 two cycles after EX, stays 1 under further inputs.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the back half of the RV32I pipeline: EX/MEM and MEM/WB
// pipeline records, the data-memory handshake state type and the x0 index.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int          XLEN_W = 32;
    localparam logic [4:0]  X0     = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic [XLEN_W-1:0] alu_result;
        logic [XLEN_W-1:0] store_data;
        logic              is_halt;
    } ex_mem_t;

    typedef struct packed {
        logic              valid;
        logic [4:0]        rd;
        logic              reg_write;
        logic [XLEN_W-1:0] data;
    } mem_wb_t;

    // A stage requests a register-file write (and thus forwarding) only for
    // real instructions that write a register other than x0.
    function automatic logic writes_rd(input logic valid, input logic reg_write,
                                       input logic [4:0] rd);
        return valid & reg_write & (rd != X0);
    endfunction

endpackage

// File: rtl/dmem_handshake.sv
// -----------------------------------------------------------------------------
// dmem_handshake
// Ready/valid handshake for the single outstanding data-memory access of the
// instruction held in EX/MEM.
//   clk, reset       : clock, synchronous active-high reset
//   access           : EX/MEM holds a valid load or store
//   is_store         : the access is a store
//   addr, wdata      : address and store data from EX/MEM
//   dmem_ready       : memory completes the access this cycle
//   dmem_req/we/addr/wdata : request to data memory
//   mem_stall        : EX/MEM must hold, MEM/WB takes a bubble
// -----------------------------------------------------------------------------
module dmem_handshake
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            access,
    input  logic            is_store,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            dmem_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            mem_stall
);

    mem_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (access && !dmem_ready) state <= WAIT;
                WAIT:    if (dmem_ready || !access) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The request is issued in the same cycle the instruction reaches EX/MEM.
    // While waiting, EX/MEM is frozen, so address/data/we stay stable.
    assign dmem_req   = access | (state == WAIT);
    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = dmem_req ? addr  : '0;
    assign dmem_wdata = dmem_req ? wdata : '0;

    // Ready completes the access in the cycle it arrives: no stall that cycle.
    assign mem_stall  = dmem_req & ~dmem_ready;

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// ex_mem_wb_pipe
// EX/MEM and MEM/WB pipeline registers with the data-memory handshake between
// them. Produces forwarding sources and the write-back record.
//   clk, reset              : clock, synchronous active-high reset
//   ex_*                    : EX-stage instruction fields (ex_valid=0 is a bubble)
//   dmem_*                  : data-memory request / response
//   mem_stall               : EX/MEM cannot advance; upstream holds
//   ex_mem_rd/RW/alu_result : EX/MEM forwarding source
//   mem_wb_rd/RW/data       : MEM/WB write-back record and forwarding source
//   halted                  : sticky, a halt instruction retired
//   stall_cycles            : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module ex_mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_mem_to_reg,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            ex_is_halt,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic [4:0]      ex_mem_rd,
    output logic            ex_mem_RW,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [4:0]      mem_wb_rd,
    output logic            mem_wb_RW,
    output logic [XLEN-1:0] mem_wb_data,
    output logic            halted,
    output logic [31:0]     stall_cycles
);

    ex_mem_t ex_mem_q;
    mem_wb_t mem_wb_q;
    logic    access;

    assign access = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write);

    dmem_handshake #(.XLEN(XLEN)) u_hs (
        .clk        (clk),
        .reset      (reset),
        .access     (access),
        .is_store   (ex_mem_q.mem_write),
        .addr       (ex_mem_q.alu_result),
        .wdata      (ex_mem_q.store_data),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .mem_stall  (mem_stall)
    );

    // EX/MEM: frozen while the memory access is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem_q <= '0;
        end else if (!mem_stall) begin
            ex_mem_q.valid      <= ex_valid;
            ex_mem_q.rd         <= ex_rd;
            ex_mem_q.reg_write  <= ex_reg_write;
            ex_mem_q.mem_read   <= ex_mem_read;
            ex_mem_q.mem_write  <= ex_mem_write;
            ex_mem_q.mem_to_reg <= ex_mem_to_reg;
            ex_mem_q.alu_result <= ex_alu_result;
            ex_mem_q.store_data <= ex_store_data;
            ex_mem_q.is_halt    <= ex_is_halt;
        end
    end

    // MEM/WB: a stalled cycle retires nothing, so it receives a bubble.
    always_ff @(posedge clk) begin
        if (reset || mem_stall) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q.valid     <= ex_mem_q.valid;
            mem_wb_q.rd        <= ex_mem_q.rd;
            mem_wb_q.reg_write <= ex_mem_q.reg_write;
            mem_wb_q.data      <= ex_mem_q.mem_to_reg ? dmem_rdata : ex_mem_q.alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (!mem_stall && ex_mem_q.valid && ex_mem_q.is_halt)
                halted <= 1'b1;
            if (mem_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    assign ex_mem_rd         = ex_mem_q.rd;
    assign ex_mem_RW         = writes_rd(ex_mem_q.valid, ex_mem_q.reg_write, ex_mem_q.rd);
    assign ex_mem_alu_result = ex_mem_q.alu_result;
    assign mem_wb_rd         = mem_wb_q.rd;
    assign mem_wb_RW         = writes_rd(mem_wb_q.valid, mem_wb_q.reg_write, mem_wb_q.rd);
    assign mem_wb_data       = mem_wb_q.data;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_wb_pipe
// Self-checking bench: directed cycle table, reset-in-wait and halt sequences,
// then randomized traffic against an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_ex_mem_wb_pipe;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] sd;
        logic        halt;
    } ex_t;

    typedef struct {
        ex_t         ex;
        logic        rdy;
        logic [31:0] rdata;
        logic        em_rw;
        logic [4:0]  em_rd;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic [31:0] scnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    ex_t         ex_in;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_req, dmem_we, mem_stall, ex_mem_RW, mem_wb_RW, halted;
    logic [31:0] dmem_addr, dmem_wdata, ex_mem_alu_result, mem_wb_data, stall_cycles;
    logic [4:0]  ex_mem_rd, mem_wb_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_wb_pipe #(.XLEN(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_valid          (ex_in.valid),
        .ex_rd             (ex_in.rd),
        .ex_reg_write      (ex_in.rw),
        .ex_mem_read       (ex_in.mr),
        .ex_mem_write      (ex_in.mw),
        .ex_mem_to_reg     (ex_in.m2r),
        .ex_alu_result     (ex_in.alu),
        .ex_store_data     (ex_in.sd),
        .ex_is_halt        (ex_in.halt),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ready        (dmem_ready),
        .dmem_rdata        (dmem_rdata),
        .mem_stall         (mem_stall),
        .ex_mem_rd         (ex_mem_rd),
        .ex_mem_RW         (ex_mem_RW),
        .ex_mem_alu_result (ex_mem_alu_result),
        .mem_wb_rd         (mem_wb_rd),
        .mem_wb_RW         (mem_wb_RW),
        .mem_wb_data       (mem_wb_data),
        .halted            (halted),
        .stall_cycles      (stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ex_t bubble();
        return '0;
    endfunction
    function automatic ex_t alu_op(input logic [4:0] rd, input logic [31:0] res);
        ex_t e = '0;
        e.valid = 1'b1; e.rd = rd; e.rw = 1'b1; e.alu = res;
        return e;
    endfunction
    function automatic ex_t load_op(input logic [4:0] rd, input logic [31:0] addr);
        ex_t e = '0;
        e.valid = 1'b1; e.rd = rd; e.rw = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.alu = addr;
        return e;
    endfunction
    function automatic ex_t store_op(input logic [31:0] addr, input logic [31:0] data);
        ex_t e = '0;
        e.valid = 1'b1; e.mw = 1'b1; e.alu = addr; e.sd = data;
        return e;
    endfunction
    function automatic ex_t halt_op();
        ex_t e = '0;
        e.valid = 1'b1; e.halt = 1'b1;
        return e;
    endfunction

    function automatic ex_t rand_ex();
        ex_t e = '0;
        int  kind = $urandom_range(0, 3);
        e.valid = ($urandom_range(0, 3) != 0);
        e.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        e.alu   = $urandom;
        e.sd    = $urandom;
        e.halt  = ($urandom_range(0, 63) == 0);
        case (kind)
            2:       begin e.rw = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; end
            3:       begin e.mw = 1'b1; end
            default: begin e.rw = 1'($urandom_range(0, 1)); end
        endcase
        return e;
    endfunction

    function automatic vec_t row(input ex_t e, input logic rdy, input logic [31:0] rdata,
                                 input logic em_rw, input logic [4:0] em_rd,
                                 input logic wb_rw, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                                 input logic req, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic stall, input logic [31:0] scnt);
        vec_t v;
        v.ex = e; v.rdy = rdy; v.rdata = rdata;
        v.em_rw = em_rw; v.em_rd = em_rd;
        v.wb_rw = wb_rw; v.wb_rd = wb_rd; v.wb_data = wb_data;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.stall = stall; v.scnt = scnt;
        return v;
    endfunction

    // Leaves the bench just after a rising edge with reset released.
    task automatic do_reset();
        reset      = 1'b1;
        ex_in      = bubble();
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Reference model state: the instruction waiting for memory and the
    // last retired write-back record.
    ex_t         m_em;
    logic        m_wb_rw;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    logic        m_halted;
    logic [31:0] m_stalls;

    vec_t tbl[12];

    initial begin
        // Watchdog: the bench never waits on a DUT event, but never hang.
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        dmem_ready = 1'b1;   // ready with no request must be ignored
        @(negedge clk);
        chk("rst ex_mem_rd", ex_mem_rd, 0);
        chk("rst ex_mem_RW", ex_mem_RW, 0);
        chk("rst ex_mem_alu", ex_mem_alu_result, 0);
        chk("rst mem_wb_rd", mem_wb_rd, 0);
        chk("rst mem_wb_RW", mem_wb_RW, 0);
        chk("rst mem_wb_data", mem_wb_data, 0);
        chk("rst dmem_req", dmem_req, 0);
        chk("rst dmem_we", dmem_we, 0);
        chk("rst dmem_addr", dmem_addr, 0);
        chk("rst mem_stall", mem_stall, 0);
        chk("rst halted", halted, 0);
        chk("rst stall_cycles", stall_cycles, 0);

        // ---------------- directed cycle table ----------------
        //                 ex                         rdy rdata         emRW emRd wbRW wbRd wbData        req we addr     wdata  stl scnt
        tbl[0]  = row(alu_op(5, 32'h1234),          0, 0,            0,   0,   0,   0,   0,            0,  0, 0,       0,     0,  0);
        tbl[1]  = row(alu_op(0, 32'h99),            0, 0,            1,   5,   0,   0,   0,            0,  0, 0,       0,     0,  0);
        tbl[2]  = row(bubble(),                     0, 0,            0,   0,   1,   5,   32'h1234,     0,  0, 0,       0,     0,  0);
        tbl[3]  = row(load_op(7, 32'h40),           0, 0,            0,   0,   0,   0,   0,            0,  0, 0,       0,     0,  0);
        tbl[4]  = row(alu_op(9, 32'h777),           0, 32'h1111,     1,   7,   0,   0,   0,            1,  0, 32'h40,  0,     1,  0);
        tbl[5]  = row(alu_op(9, 32'h777),           0, 32'h2222,     1,   7,   0,   0,   0,            1,  0, 32'h40,  0,     1,  1);
        tbl[6]  = row(alu_op(9, 32'h777),           0, 32'h3333,     1,   7,   0,   0,   0,            1,  0, 32'h40,  0,     1,  2);
        tbl[7]  = row(alu_op(9, 32'h777),           1, 32'hDEADBEEF, 1,   7,   0,   0,   0,            1,  0, 32'h40,  0,     0,  3);
        tbl[8]  = row(bubble(),                     0, 0,            1,   9,   1,   7,   32'hDEADBEEF, 0,  0, 0,       0,     0,  3);
        tbl[9]  = row(store_op(32'h80, 32'h55),     1, 32'h4444,     0,   0,   1,   9,   32'h777,      0,  0, 0,       0,     0,  3);
        tbl[10] = row(bubble(),                     1, 32'h5555,     0,   0,   0,   0,   0,            1,  1, 32'h80,  32'h55,0,  3);
        tbl[11] = row(bubble(),                     0, 0,            0,   0,   0,   0,   0,            0,  0, 0,       0,     0,  3);

        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            ex_in      = tbl[i].ex;
            dmem_ready = tbl[i].rdy;
            dmem_rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("row%0d ex_mem_RW", i), ex_mem_RW, tbl[i].em_rw);
            chk($sformatf("row%0d ex_mem_rd", i), ex_mem_rd, tbl[i].em_rd);
            chk($sformatf("row%0d mem_wb_RW", i), mem_wb_RW, tbl[i].wb_rw);
            if (tbl[i].wb_rw) begin
                chk($sformatf("row%0d mem_wb_rd", i), mem_wb_rd, tbl[i].wb_rd);
                chk($sformatf("row%0d mem_wb_data", i), mem_wb_data, tbl[i].wb_data);
            end
            chk($sformatf("row%0d dmem_req", i), dmem_req, tbl[i].req);
            chk($sformatf("row%0d mem_stall", i), mem_stall, tbl[i].stall);
            chk($sformatf("row%0d stall_cycles", i), stall_cycles, tbl[i].scnt);
            chk($sformatf("row%0d halted", i), halted, 0);
            if (tbl[i].req) begin
                chk($sformatf("row%0d dmem_we", i), dmem_we, tbl[i].we);
                chk($sformatf("row%0d dmem_addr", i), dmem_addr, tbl[i].addr);
                if (tbl[i].we)
                    chk($sformatf("row%0d dmem_wdata", i), dmem_wdata, tbl[i].wdata);
            end
        end

        // ---------------- reset while waiting on memory ----------------
        do_reset();
        ex_in = load_op(3, 32'h100);
        @(posedge clk);
        #1 ex_in = alu_op(4, 32'h1);
        @(negedge clk);
        chk("rw stall before reset", mem_stall, 1);
        chk("rw req before reset", dmem_req, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        ex_in = bubble();
        @(negedge clk);
        chk("rw dmem_req", dmem_req, 0);
        chk("rw mem_stall", mem_stall, 0);
        chk("rw ex_mem_RW", ex_mem_RW, 0);
        chk("rw mem_wb_RW", mem_wb_RW, 0);
        chk("rw stall_cycles", stall_cycles, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rw dmem_req idle", dmem_req, 0);
        chk("rw mem_wb_RW later", mem_wb_RW, 0);

        // ---------------- halt ----------------
        do_reset();
        ex_in = halt_op();
        @(negedge clk);
        chk("halt cyc0", halted, 0);
        @(posedge clk);
        #1 ex_in = bubble();
        @(negedge clk);
        chk("halt cyc1", halted, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 ex_in = alu_op(5'($urandom_range(1, 31)), $urandom);
            dmem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("halt sticky%0d", i), halted, 1);
        end

        // ---------------- randomized vs reference model ----------------
        do_reset();
        m_em = '0; m_wb_rw = 0; m_wb_rd = 0; m_wb_data = 0; m_halted = 0; m_stalls = 0;
        begin
            logic prev_stall = 1'b0;
            logic acc, st;
            for (int c = 0; c < 1500; c++) begin
                if (!prev_stall) ex_in = rand_ex();   // upstream holds while stalled
                dmem_ready = ($urandom_range(0, 2) != 0);
                dmem_rdata = $urandom;
                @(negedge clk);
                acc = m_em.valid & (m_em.mr | m_em.mw);
                st  = acc & ~dmem_ready;
                chk("rnd ex_mem_RW", ex_mem_RW, m_em.valid & m_em.rw & (m_em.rd != 0));
                if (m_em.valid) begin
                    chk("rnd ex_mem_rd", ex_mem_rd, m_em.rd);
                    chk("rnd ex_mem_alu", ex_mem_alu_result, m_em.alu);
                end
                chk("rnd mem_wb_RW", mem_wb_RW, m_wb_rw);
                if (m_wb_rw) begin
                    chk("rnd mem_wb_rd", mem_wb_rd, m_wb_rd);
                    chk("rnd mem_wb_data", mem_wb_data, m_wb_data);
                end
                chk("rnd dmem_req", dmem_req, acc);
                chk("rnd mem_stall", mem_stall, st);
                if (acc) begin
                    chk("rnd dmem_we", dmem_we, m_em.mw);
                    chk("rnd dmem_addr", dmem_addr, m_em.alu);
                    if (m_em.mw) chk("rnd dmem_wdata", dmem_wdata, m_em.sd);
                end
                chk("rnd halted", halted, m_halted);
                chk("rnd stall_cycles", stall_cycles, m_stalls);

                // advance the model by one clock
                if (st) begin
                    m_wb_rw = 0;
                    if (m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
                end else begin
                    m_wb_rw   = m_em.valid & m_em.rw & (m_em.rd != 0);
                    m_wb_rd   = m_em.rd;
                    m_wb_data = m_em.m2r ? dmem_rdata : m_em.alu;
                    if (m_em.valid && m_em.halt) m_halted = 1;
                    m_em = ex_in;
                end
                prev_stall = st;
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
